// File: rtl/score_ssd_driver.sv
// score_ssd_driver: converts a 16-bit binary score to four BCD digits with a
// sequential double-dabble engine, then time-multiplexes those digits onto a
// 4-digit common-anode seven-segment display. Scores above 9999 show 9999.
//
// Optional feature macro: LEADING_ZERO_BLANK_EN
//   defined     -> digits 3..1 are blanked while they and every more
//                  significant digit are zero (digit 0 is always shown)
//   not defined -> all four digits are always shown, including leading zeros
//
// Ports:
//   clk    in   1  system clock
//   rst_n  in   1  asynchronous active-low reset
//   score  in  16  unsigned binary score, sampled only while idle
//   an     out  4  digit enables, active-low, an[0] = ones digit
//   seg    out  7  cathodes {g,f,e,d,c,b,a}, active-low
//   dp     out  1  decimal point, active-low, held off
//   busy   out  1  high while a conversion is in flight
module score_ssd_driver #(
    parameter int unsigned SCAN_BITS = 18
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] score,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        busy
);

    localparam int unsigned SCORE_W = 16;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned DIGITS  = 4;
    localparam logic [SCORE_W-1:0] SAT_LIMIT  = 16'd9999;
    localparam logic [SCORE_W-1:0] SAT_DIGITS = 16'h9999;
    localparam logic [6:0]         SEG_BLANK  = 7'b1111111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_LOAD = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [SCORE_W-1:0]     score_last_q, score_last_d;
    logic [SCORE_W-1:0]     shreg_q, shreg_d;
    logic [SCORE_W-1:0]     bcd_q, bcd_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [SCORE_W-1:0]     digits_q, digits_d;
    logic                   busy_q, busy_d;
    logic [SCAN_BITS-1:0]   scan_q, scan_d;
    logic [DIGITS-1:0]      an_q, an_d;
    logic [6:0]             seg_q, seg_d;
    logic                   dp_q, dp_d;

    logic [SCORE_W-1:0]     bcd_adj;
    logic [2*SCORE_W-1:0]   dabble_shift;
    logic [1:0]             scan_sel;
    logic [3:0]             scan_nib;
    logic                   scan_blank;

    // Active-low seven-segment pattern, {g,f,e,d,c,b,a}
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'd0:    pat = 7'b1000000;
            4'd1:    pat = 7'b1111001;
            4'd2:    pat = 7'b0100100;
            4'd3:    pat = 7'b0110000;
            4'd4:    pat = 7'b0011001;
            4'd5:    pat = 7'b0010010;
            4'd6:    pat = 7'b0000010;
            4'd7:    pat = 7'b1111000;
            4'd8:    pat = 7'b0000000;
            4'd9:    pat = 7'b0010000;
            default: pat = SEG_BLANK;
        endcase
        return pat;
    endfunction

    // One double-dabble step: add 3 to every nibble >= 5, then shift left
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        dabble_shift = {bcd_adj, shreg_q} << 1;
    end

    // Converter next-state and datapath
    always_comb begin
        state_d      = state_q;
        score_last_d = score_last_q;
        shreg_d      = shreg_q;
        bcd_d        = bcd_q;
        cnt_d        = cnt_q;
        digits_d     = digits_q;

        case (state_q)
            ST_IDLE: begin
                if (score != score_last_q) begin
                    score_last_d = score;
                    shreg_d      = score;
                    bcd_d        = '0;
                    cnt_d        = '0;
                    state_d      = ST_CONV;
                end
            end
            ST_CONV: begin
                bcd_d   = dabble_shift[2*SCORE_W-1:SCORE_W];
                shreg_d = dabble_shift[SCORE_W-1:0];
                cnt_d   = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                // Saturate on the captured value so the live input cannot race it
                digits_d = (score_last_q > SAT_LIMIT) ? SAT_DIGITS : bcd_q;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // Display scan: select one digit from the top two scan counter bits
    always_comb begin
        scan_d   = scan_q + SCAN_BITS'(1);
        scan_sel = scan_q[SCAN_BITS-1 -: 2];
        scan_nib = 4'(digits_q >> {scan_sel, 2'b00});

`ifdef LEADING_ZERO_BLANK_EN
        // A digit is blank when it and all more significant digits are zero
        case (scan_sel)
            2'd3:    scan_blank = (digits_q[15:12] == 4'd0);
            2'd2:    scan_blank = (digits_q[15:8]  == 8'd0);
            2'd1:    scan_blank = (digits_q[15:4]  == 12'd0);
            default: scan_blank = 1'b0;
        endcase
`else
        scan_blank = 1'b0;
`endif

        an_d  = ~(4'b0001 << scan_sel);
        seg_d = scan_blank ? SEG_BLANK : seg_decode(scan_nib);
        dp_d  = 1'b1;
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            score_last_q <= '0;
            shreg_q      <= '0;
            bcd_q        <= '0;
            cnt_q        <= '0;
            digits_q     <= '0;
            busy_q       <= 1'b0;
            scan_q       <= '0;
            an_q         <= 4'b1111;
            seg_q        <= SEG_BLANK;
            dp_q         <= 1'b1;
        end else begin
            state_q      <= state_d;
            score_last_q <= score_last_d;
            shreg_q      <= shreg_d;
            bcd_q        <= bcd_d;
            cnt_q        <= cnt_d;
            digits_q     <= digits_d;
            busy_q       <= busy_d;
            scan_q       <= scan_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
        end
    end

    assign an   = an_q;
    assign seg  = seg_q;
    assign dp   = dp_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_score_ssd_driver.sv
// Bench for score_ssd_driver with SCAN_BITS=4. Expected display content is
// derived from decimal arithmetic on the score (saturated at 9999); the
// digit scan is predicted from the number of clock edges since reset release.
module tb_score_ssd_driver;

    localparam int unsigned SB = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] score = 16'd0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        busy;

    int total = 0;
    int bad   = 0;
    int edges;
    int shown = 0;
    int prev  = 0;

    score_ssd_driver #(.SCAN_BITS(SB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .score (score),
        .an    (an),
        .seg   (seg),
        .dp    (dp),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    // Edges since reset release; edge n shows digit ((n-1) >> (SB-2)) & 3
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edges <= 0;
        else        edges <= edges + 1;
    end

    function automatic logic [6:0] pat(input int n);
        case (n)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic int sat(input int s);
        return (s > 9999) ? 9999 : s;
    endfunction

    function automatic logic [6:0] exp_seg(input int v, input int i);
        int p = 1;
        for (int k = 0; k < i; k++) p = p * 10;
`ifdef LEADING_ZERO_BLANK_EN
        if (i > 0 && v < p) return 7'b1111111;
`endif
        return pat((v / p) % 10);
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one cycle and check the scanned digit against the model
    task automatic tick();
        int d;
        logic [3:0] ea;
        @(posedge clk);
        #1;
        d  = ((edges - 1) >> (SB - 2)) & 3;
        ea = 4'b0001 << d;
        ea = ~ea;
        chk("an", 16'(an), 16'(ea));
        chk("seg", 16'(seg), 16'(exp_seg(shown, d)));
        chk("dp", 16'(dp), 16'd1);
    endtask

    // Score already applied; the next edge captures it
    task automatic run_conv(input int v);
        for (int k = 1; k <= 18; k++) begin
            tick();
            chk("busy", 16'(busy), (k <= 17) ? 16'd1 : 16'd0);
            if (k == 18) shown = sat(v);
        end
        prev = v;
    endtask

    task automatic convert(input int v);
        score = 16'(v);
        run_conv(v);
    endtask

    task automatic frame();
        for (int k = 0; k < 16; k++) begin
            tick();
            chk("busy_idle", 16'(busy), 16'd0);
        end
    endtask

    initial begin
        int v;

        // Reset held
        repeat (2) @(negedge clk);
        chk("rst_an", 16'(an), 16'hF);
        chk("rst_seg", 16'(seg), 16'h7F);
        chk("rst_dp", 16'(dp), 16'd1);
        chk("rst_busy", 16'(busy), 16'd0);
        rst_n = 1'b1;
        tick();
        chk("first_an", 16'(an), 16'hE);
        chk("first_seg", 16'(seg), 16'h40);
        repeat (3) tick();
        frame();

        // Directed conversions: normal, saturation, small values
        convert(1234);
        frame();
        convert(10000);
        frame();
        convert(65535);
        frame();
        convert(40);
        frame();
        convert(0);
        frame();

        // Score changes mid-conversion: 5 converts first, then 77
        score = 16'd5;
        for (int k = 1; k <= 18; k++) begin
            tick();
            if (k == 4) score = 16'd77;
            chk("busy_a", 16'(busy), (k <= 17) ? 16'd1 : 16'd0);
            if (k == 18) shown = 5;
        end
        run_conv(77);
        frame();

        // Async reset in the middle of a conversion
        score = 16'd1234;
        for (int k = 1; k <= 7; k++) begin
            tick();
            chk("busy_b", 16'(busy), 16'd1);
        end
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_an", 16'(an), 16'hF);
        chk("arst_seg", 16'(seg), 16'h7F);
        chk("arst_dp", 16'(dp), 16'd1);
        chk("arst_busy", 16'(busy), 16'd0);
        shown = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_conv(1234);
        frame();

        // Randomized scores, biased toward small values to exercise leading zeros
        for (int n = 0; n < 10; n++) begin
            case (n % 3)
                0:       v = int'($urandom_range(0, 65535));
                1:       v = int'($urandom_range(0, 9999));
                default: v = int'($urandom_range(0, 120));
            endcase
            if (v == prev) v = (v + 1) % 65536;
            convert(v);
            frame();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
